ram32x4_arbiter: RTL
====================

RAM32X4_ARBITER -- requirements
Module: ram32x4_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset that is asynchronous and active-low.
REQ-003 SHALL have ports req0_valid/req1_valid, input, 1 bit each: requester N presents a request.
REQ-004 SHALL have ports req0_ready/req1_ready, output, 1 bit each: request N is accepted this cycle.
REQ-005 SHALL have ports req0_we/req1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-006 SHALL have ports req0_addr/req1_addr, input, 5 bits each: RAM word address.
REQ-007 SHALL have ports req0_wdata/req1_wdata, input, 4 bits each: write data.
REQ-008 SHALL have ports rsp0_valid/rsp1_valid, output, 1 bit each: one-cycle read-data strobe to requester N.
REQ-009 SHALL have ports rsp0_rdata/rsp1_rdata, output, 4 bits each: both driven combinationally from ram_q.
REQ-010 SHALL have ports ram_address (5 bits), ram_data (4 bits) and ram_wren (1 bit), all outputs, all registered: ram32x4 inputs.
REQ-011 SHALL have port ram_q, input, 4 bits: ram32x4 registered output.
REQ-012 SHALL have port busy, output, 1 bit: high while the RAM clear sweep runs.

Function
REQ-013 SHALL use states CLEAR and SERVE; CLEAR exists only per REQ-027.
REQ-014 In SERVE, SHALL grant at most one request per cycle: readyN = SERVE and reqN_valid and (grant = N).
REQ-015 Arbitration SHALL be round-robin on conflict: the requester not granted most recently wins; a sole requester wins unconditionally.
REQ-016 A request SHALL transfer when valid and ready are both high; at that edge, ram_address/ram_data/ram_wren SHALL load addr/wdata/we.
REQ-017 In a cycle with no transfer, ram_wren SHALL be 0, and ram_address and ram_data SHALL hold their values.
REQ-018 A read accepted at edge A SHALL raise rspN_valid for exactly the cycle after edge A+2; rsp_valid is 3 cycles after ready.
REQ-019 Writes SHALL produce no response.
REQ-020 Back-to-back transfers SHALL be supported (1 transfer/cycle); a two-stage {valid, id} pipeline SHALL track outstanding reads.
REQ-021 A read accepted one cycle after a write to the same address SHALL return the new data.
REQ-022 Requesters SHALL hold valid/we/addr/wdata stable until ready; the block need not check this.

Reset
REQ-023 While reset_n = 0, outputs SHALL be: ram_address = 0, ram_data = 0, ram_wren = 0, rsp*_valid = 0, req*_ready = 0.
REQ-024 Reset SHALL make requester 0 win the first conflict.
REQ-025 Reset asserted mid-operation SHALL flush the read pipeline; no response for in-flight reads SHALL ever be emitted.
REQ-026 After reset_n rises, the block SHALL enter CLEAR if RAM32X4_ARBITER_CLEAR_EN is defined, otherwise SERVE.

Configuration
REQ-027 Macro RAM32X4_ARBITER_CLEAR_EN defined: CLEAR SHALL write 0 to addresses 0..31 in order, one per cycle (ram_wren = 1), with busy = 1 and both ready = 0.
- After address 31 is written, the block SHALL enter SERVE.
- The first request may be accepted 32 cycles after reset release.
REQ-028 Macro undefined: no CLEAR state, no clear counter, busy tied 0, RAM contents undefined after power-up.

Verification
REQ-029 Write req0 addr 0x15 data 0xA, then read req0 addr 0x15 -> rsp0_valid 3 cycles after read accept, rsp0_rdata = 0xA, rsp1_valid stays 0.
REQ-030 req0 and req1 reads held valid together after reset -> grants alternate 0,1,0,1; responses arrive on matching rspN in the same order.
REQ-031 Write addr 0x0A data 0x5 (req1), then read addr 0x0A (req0) on the next cycle -> rsp0_rdata = 0x5.
REQ-032 Issue a read, then pulse reset_n low 1 cycle later -> no rsp*_valid pulse; ram_wren = 0 while reset_n = 0.
REQ-033 With RAM32X4_ARBITER_CLEAR_EN: reset, then hold req0 read addr 0x1F -> busy high for 32 cycles, ready low throughout, then read returns 0x0.
REQ-034 Single requester streaming writes to addresses 0..31 -> one accept per cycle, ram_wren high 32 consecutive cycles.

Source files
------------

// File: rtl/ram32x4_arbiter.sv
// Two-requester round-robin front end for a ram32x4 (registered in and out); reads answer 3 cycles after accept, one grant per cycle, losers wait on ready.
// Optional power-up zero sweep of all 32 words when RAM32X4_ARBITER_CLEAR_EN is defined (busy high, ready low while it runs).
module ram32x4_arbiter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_we,
    input  logic [4:0] req0_addr,
    input  logic [3:0] req0_wdata,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_we,
    input  logic [4:0] req1_addr,
    input  logic [3:0] req1_wdata,
    output logic       rsp0_valid,
    output logic [3:0] rsp0_rdata,
    output logic       rsp1_valid,
    output logic [3:0] rsp1_rdata,
    output logic [4:0] ram_address,
    output logic [3:0] ram_data,
    output logic       ram_wren,
    input  logic [3:0] ram_q,
    output logic       busy
);

    logic       serve;
    logic       clearing;

`ifdef RAM32X4_ARBITER_CLEAR_EN
    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 5'd1;
            if (clr_cnt_q == 5'd31) begin
                state_d = SERVE;
            end
        end
    end

    // Gating with reset_n keeps ready/busy low while reset is held.
    assign serve    = reset_n && (state_q == SERVE);
    assign clearing = reset_n && (state_q == CLEAR);
`else
    assign serve    = reset_n;
    assign clearing = 1'b0;
`endif

    assign busy = clearing;

    // last1_q: requester 1 was granted most recently; resets to 1 so requester 0 wins first.
    logic last1_q, last1_d;
    logic grant1;
    logic xfer0, xfer1;

    always_comb begin
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant1 = ~last1_q;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    assign xfer0      = serve && req0_valid && !grant1;
    assign xfer1      = serve && req1_valid &&  grant1;
    assign req0_ready = xfer0;
    assign req1_ready = xfer1;

    always_comb begin
        last1_d = last1_q;
        if (xfer1) begin
            last1_d = 1'b1;
        end else if (xfer0) begin
            last1_d = 1'b0;
        end
    end

    logic [4:0] ram_address_q, ram_address_d;
    logic [3:0] ram_data_q, ram_data_d;
    logic       ram_wren_q, ram_wren_d;

    always_comb begin
        ram_address_d = ram_address_q;
        ram_data_d    = ram_data_q;
        ram_wren_d    = 1'b0;
        if (xfer0) begin
            ram_address_d = req0_addr;
            ram_data_d    = req0_wdata;
            ram_wren_d    = req0_we;
        end else if (xfer1) begin
            ram_address_d = req1_addr;
            ram_data_d    = req1_wdata;
            ram_wren_d    = req1_we;
        end
`ifdef RAM32X4_ARBITER_CLEAR_EN
        if (clearing) begin
            ram_address_d = clr_cnt_q;
            ram_data_d    = '0;
            ram_wren_d    = 1'b1;
        end
`endif
    end

    // Read tracking: two {valid, id} stages cover the RAM's address and output
    // registers; the response strobe register lines up with ram_q.
    logic rd1_vld_q, rd1_vld_d;
    logic rd1_id_q,  rd1_id_d;
    logic rd2_vld_q;
    logic rd2_id_q;
    logic rsp0_vld_q, rsp0_vld_d;
    logic rsp1_vld_q, rsp1_vld_d;

    always_comb begin
        rd1_vld_d  = (xfer0 && !req0_we) || (xfer1 && !req1_we);
        rd1_id_d   = xfer1;
        rsp0_vld_d = rd2_vld_q && !rd2_id_q;
        rsp1_vld_d = rd2_vld_q &&  rd2_id_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last1_q       <= 1'b1;
            ram_address_q <= '0;
            ram_data_q    <= '0;
            ram_wren_q    <= 1'b0;
            rd1_vld_q     <= 1'b0;
            rd1_id_q      <= 1'b0;
            rd2_vld_q     <= 1'b0;
            rd2_id_q      <= 1'b0;
            rsp0_vld_q    <= 1'b0;
            rsp1_vld_q    <= 1'b0;
        end else begin
            last1_q       <= last1_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
            ram_wren_q    <= ram_wren_d;
            rd1_vld_q     <= rd1_vld_d;
            rd1_id_q      <= rd1_id_d;
            rd2_vld_q     <= rd1_vld_q;
            rd2_id_q      <= rd1_id_q;
            rsp0_vld_q    <= rsp0_vld_d;
            rsp1_vld_q    <= rsp1_vld_d;
        end
    end

    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign ram_wren    = ram_wren_q;
    assign rsp0_valid  = rsp0_vld_q;
    assign rsp1_valid  = rsp1_vld_q;
    assign rsp0_rdata  = ram_q;
    assign rsp1_rdata  = ram_q;

endmodule
